// File: rtl/rgb_fade_seq.sv
// Colour-wheel fade sequencer: walks R/G/B PWM duties around six hue phases,
// one channel ramping at a time, with a dwell pause at each colour endpoint.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | outputs parked at zero, waiting for start
// RUN    | ticks advance the dwell counter or the ramping channel
// HOLD   | frozen by pause; ticks ignored, dwell counter preserved
module rgb_fade_seq #(
    parameter int unsigned STEP  = 8,
    parameter int unsigned DWELL = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic       pause,
    input  logic       stop,
    output logic [7:0] R_time,
    output logic [7:0] G_time,
    output logic [7:0] B_time,
    output logic [2:0] phase,
    output logic       busy,
    output logic       paused,
    output logic       phase_done,
    output logic       wrap
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam logic [1:0] CH_R = 2'd0;
    localparam logic [1:0] CH_G = 2'd1;
    localparam logic [1:0] CH_B = 2'd2;

    localparam logic [8:0] STEP9  = 9'(STEP);
    localparam logic [7:0] DWELL8 = 8'(DWELL);

    logic [1:0] state_q, state_d;
    logic [7:0] r_q, r_d;
    logic [7:0] g_q, g_d;
    logic [7:0] b_q, b_d;
    logic [2:0] phase_q, phase_d;
    logic [7:0] dwell_q, dwell_d;
    logic       phase_done_q, phase_done_d;
    logic       wrap_q, wrap_d;

    logic [1:0] ch_sel;
    logic       ramp_up;
    logic [7:0] ch_val;
    logic [8:0] sum9;
    logic [8:0] diff9;
    logic [7:0] ch_next;
    logic       at_end;
    logic [2:0] phase_inc;

    always_comb begin
        ch_sel  = CH_B;
        ramp_up = 1'b0;
        case (phase_q)
            3'd0: begin ch_sel = CH_G; ramp_up = 1'b1; end
            3'd1: begin ch_sel = CH_R; ramp_up = 1'b0; end
            3'd2: begin ch_sel = CH_B; ramp_up = 1'b1; end
            3'd3: begin ch_sel = CH_G; ramp_up = 1'b0; end
            3'd4: begin ch_sel = CH_R; ramp_up = 1'b1; end
            default: begin ch_sel = CH_B; ramp_up = 1'b0; end
        endcase
    end

    always_comb begin
        ch_val = b_q;
        case (ch_sel)
            CH_R:    ch_val = r_q;
            CH_G:    ch_val = g_q;
            default: ch_val = b_q;
        endcase
    end

    // The ninth bit catches carry/borrow so the ramp saturates instead of wrapping.
    always_comb begin
        sum9  = {1'b0, ch_val} + STEP9;
        diff9 = {1'b0, ch_val} - STEP9;
        if (ramp_up) begin
            ch_next = sum9[8] ? 8'hFF : sum9[7:0];
            at_end  = sum9[8] || (sum9[7:0] == 8'hFF);
        end else begin
            ch_next = diff9[8] ? 8'h00 : diff9[7:0];
            at_end  = diff9[8] || (diff9[7:0] == 8'h00);
        end
        phase_inc = (phase_q == 3'd5) ? 3'd0 : phase_q + 3'd1;
    end

    always_comb begin
        state_d      = state_q;
        r_d          = r_q;
        g_d          = g_q;
        b_d          = b_q;
        phase_d      = phase_q;
        dwell_d      = dwell_q;
        phase_done_d = 1'b0;
        wrap_d       = 1'b0;

        if (stop) begin
            state_d = S_IDLE;
            r_d     = 8'h00;
            g_d     = 8'h00;
            b_d     = 8'h00;
            phase_d = 3'd0;
            dwell_d = 8'h00;
        end else if (start) begin
            state_d = S_RUN;
            r_d     = 8'hFF;
            g_d     = 8'h00;
            b_d     = 8'h00;
            phase_d = 3'd0;
            dwell_d = 8'h00;
        end else if (pause && (state_q != S_IDLE)) begin
            state_d = (state_q == S_RUN) ? S_HOLD : S_RUN;
        end else if (tick && (state_q == S_RUN)) begin
            if (dwell_q != 8'h00) begin
                dwell_d = dwell_q - 8'd1;
            end else begin
                case (ch_sel)
                    CH_R:    r_d = ch_next;
                    CH_G:    g_d = ch_next;
                    default: b_d = ch_next;
                endcase
                if (at_end) begin
                    phase_d      = phase_inc;
                    dwell_d      = DWELL8;
                    phase_done_d = 1'b1;
                    wrap_d       = (phase_q == 3'd5);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            r_q          <= 8'h00;
            g_q          <= 8'h00;
            b_q          <= 8'h00;
            phase_q      <= 3'd0;
            dwell_q      <= 8'h00;
            phase_done_q <= 1'b0;
            wrap_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            r_q          <= r_d;
            g_q          <= g_d;
            b_q          <= b_d;
            phase_q      <= phase_d;
            dwell_q      <= dwell_d;
            phase_done_q <= phase_done_d;
            wrap_q       <= wrap_d;
        end
    end

    assign R_time     = r_q;
    assign G_time     = g_q;
    assign B_time     = b_q;
    assign phase      = phase_q;
    assign busy       = (state_q != S_IDLE);
    assign paused     = (state_q == S_HOLD);
    assign phase_done = phase_done_q;
    assign wrap       = wrap_q;

endmodule

// File: tb/tb_rgb_fade_seq.sv
// Bench for rgb_fade_seq: three parameterisations share one stimulus stream and
// are checked every cycle against an integer colour-wheel model plus literal pins.
module tb_rgb_fade_seq;

    logic clk;
    logic rst;
    logic tick;
    logic start;
    logic pause;
    logic stop;

    logic [7:0] r_o [3];
    logic [7:0] g_o [3];
    logic [7:0] b_o [3];
    logic [2:0] ph_o [3];
    logic       busy_o [3];
    logic       paused_o [3];
    logic       pd_o [3];
    logic       wrap_o [3];

    int n_err = 0;
    int n_chk = 0;
    int wraps0 = 0;
    bit cmp_en = 0;

    int m_step  [3] = '{8, 8, 100};
    int m_dwell [3] = '{0, 4, 0};
    int ch_tab  [6] = '{1, 0, 2, 1, 0, 2};
    int up_tab  [6] = '{1, 0, 1, 0, 1, 0};

    // model state: 0 idle, 1 run, 2 hold
    int m_st  [3];
    int m_rgb [3][3];
    int m_ph  [3];
    int m_dw  [3];
    int m_pd  [3];
    int m_wr  [3];

    rgb_fade_seq #(.STEP(8), .DWELL(0)) u0 (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .pause(pause), .stop(stop),
        .R_time(r_o[0]), .G_time(g_o[0]), .B_time(b_o[0]), .phase(ph_o[0]),
        .busy(busy_o[0]), .paused(paused_o[0]), .phase_done(pd_o[0]), .wrap(wrap_o[0])
    );
    rgb_fade_seq #(.STEP(8), .DWELL(4)) u1 (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .pause(pause), .stop(stop),
        .R_time(r_o[1]), .G_time(g_o[1]), .B_time(b_o[1]), .phase(ph_o[1]),
        .busy(busy_o[1]), .paused(paused_o[1]), .phase_done(pd_o[1]), .wrap(wrap_o[1])
    );
    rgb_fade_seq #(.STEP(100), .DWELL(0)) u2 (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .pause(pause), .stop(stop),
        .R_time(r_o[2]), .G_time(g_o[2]), .B_time(b_o[2]), .phase(ph_o[2]),
        .busy(busy_o[2]), .paused(paused_o[2]), .phase_done(pd_o[2]), .wrap(wrap_o[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_st[k] = 0;
            for (int c = 0; c < 3; c++) m_rgb[k][c] = 0;
            m_ph[k] = 0;
            m_dw[k] = 0;
            m_pd[k] = 0;
            m_wr[k] = 0;
        end
    endtask

    task automatic model_step(input int k);
        int c;
        int v;
        int up;
        m_pd[k] = 0;
        m_wr[k] = 0;
        if (stop) begin
            m_st[k] = 0;
            for (int i = 0; i < 3; i++) m_rgb[k][i] = 0;
            m_ph[k] = 0;
            m_dw[k] = 0;
        end else if (start) begin
            m_st[k] = 1;
            m_rgb[k][0] = 255;
            m_rgb[k][1] = 0;
            m_rgb[k][2] = 0;
            m_ph[k] = 0;
            m_dw[k] = 0;
        end else if (pause && m_st[k] != 0) begin
            m_st[k] = (m_st[k] == 1) ? 2 : 1;
        end else if (tick && m_st[k] == 1) begin
            if (m_dw[k] > 0) begin
                m_dw[k] = m_dw[k] - 1;
            end else begin
                c  = ch_tab[m_ph[k]];
                up = up_tab[m_ph[k]];
                v  = up ? m_rgb[k][c] + m_step[k] : m_rgb[k][c] - m_step[k];
                if (v > 255) v = 255;
                if (v < 0) v = 0;
                m_rgb[k][c] = v;
                if (v == (up ? 255 : 0)) begin
                    m_ph[k] = (m_ph[k] + 1) % 6;
                    m_dw[k] = m_dwell[k];
                    m_pd[k] = 1;
                    m_wr[k] = (m_ph[k] == 0) ? 1 : 0;
                end
            end
        end
    endtask

    function automatic logic [30:0] exp_vec(input int k);
        return {8'(m_rgb[k][0]), 8'(m_rgb[k][1]), 8'(m_rgb[k][2]), 3'(m_ph[k]),
                (m_st[k] != 0), (m_st[k] == 2), 1'(m_pd[k]), 1'(m_wr[k])};
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < 3; k++) begin
                logic [30:0] act;
                act = {r_o[k], g_o[k], b_o[k], ph_o[k], busy_o[k], paused_o[k], pd_o[k], wrap_o[k]};
                n_chk++;
                if (act !== exp_vec(k)) begin
                    n_err++;
                    $display("FAIL model_u%0d t=%0t: got %h expected %h (R,G,B,phase,busy,paused,pd,wrap)",
                             k, $time, act, exp_vec(k));
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < 3; k++) model_step(k);
        end else begin
            model_reset();
        end
        #1;
        tick  = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        stop  = 1'b0;
        if (wrap_o[0]) wraps0++;
    endtask

    initial begin
        tick  = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        stop  = 1'b0;
        rst   = 1'b1;
        model_reset();
        #1 rst = 1'b0;
        cmp_en = 1'b1;
        #1;
        chk("reset_R", r_o[0], 0);
        chk("reset_busy", busy_o[0], 0);
        repeat (3) cycle();
        rst = 1'b1;
        repeat (2) cycle();
        chk("idle_after_reset_busy", busy_o[0], 0);

        // full wheel, tick every other cycle
        start = 1'b1;
        cycle();
        chk("start_R", r_o[0], 255);
        chk("start_busy", busy_o[0], 1);
        for (int i = 1; i <= 192; i++) begin
            tick = 1'b1;
            cycle();
            if (i == 1)  chk("u2_tick1_G", g_o[2], 100);
            if (i == 2)  chk("u2_tick2_G", g_o[2], 200);
            if (i == 3) begin
                chk("u2_tick3_G_sat", g_o[2], 255);
                chk("u2_tick3_phase", ph_o[2], 1);
            end
            if (i == 31) begin
                chk("u0_tick31_G", g_o[0], 248);
                chk("u0_tick31_phase", ph_o[0], 0);
            end
            if (i == 32) begin
                chk("u0_tick32_G_sat", g_o[0], 255);
                chk("u0_tick32_phase", ph_o[0], 1);
                chk("u0_tick32_pd", pd_o[0], 1);
                chk("u0_tick32_wrap", wrap_o[0], 0);
                chk("u1_tick32_phase", ph_o[1], 1);
            end
            if (i == 33) begin
                chk("u0_tick33_R", r_o[0], 247);
                chk("u0_tick33_pd", pd_o[0], 0);
            end
            if (i >= 33 && i <= 36) chk("u1_dwell_R", r_o[1], 255);
            if (i == 37) chk("u1_after_dwell_R", r_o[1], 247);
            if (i == 192) chk("u0_tick192_wrap", wrap_o[0], 1);
            cycle();
            if (i == 32) chk("u0_pd_one_cycle", pd_o[0], 0);
        end
        chk("u0_wrap_count", wraps0, 1);
        chk("u0_wheel_R", r_o[0], 255);
        chk("u0_wheel_G", g_o[0], 0);
        chk("u0_wheel_B", b_o[0], 0);
        chk("u0_wheel_phase", ph_o[0], 0);

        // pause / hold behaviour
        start = 1'b1;
        cycle();
        repeat (5) begin
            tick = 1'b1;
            cycle();
        end
        chk("pre_pause_G", g_o[0], 40);
        pause = 1'b1;
        cycle();
        chk("hold_paused", paused_o[0], 1);
        for (int i = 0; i < 10; i++) begin
            tick = 1'b1;
            cycle();
            chk("hold_G_frozen", g_o[0], 40);
        end
        pause = 1'b1;
        tick  = 1'b1;
        cycle();
        chk("resume_paused", paused_o[0], 0);
        chk("resume_tick_dropped_G", g_o[0], 40);
        tick = 1'b1;
        cycle();
        chk("resume_tick_G", g_o[0], 48);
        pause = 1'b1;
        tick  = 1'b1;
        cycle();
        chk("pause_tick_dropped_G", g_o[0], 48);
        chk("pause_tick_paused", paused_o[0], 1);
        pause = 1'b1;
        cycle();
        tick = 1'b1;
        cycle();
        chk("second_resume_G", g_o[0], 56);

        // restart while running, then stop+start collision
        start = 1'b1;
        cycle();
        chk("restart_G", g_o[0], 0);
        chk("restart_R", r_o[0], 255);
        stop  = 1'b1;
        start = 1'b1;
        cycle();
        chk("stop_start_busy", busy_o[0], 0);
        chk("stop_start_R", r_o[0], 0);
        pause = 1'b1;
        cycle();
        chk("idle_pause_ignored", paused_o[0], 0);
        tick = 1'b1;
        cycle();
        chk("idle_tick_ignored_R", r_o[0], 0);

        // asynchronous reset mid-run
        start = 1'b1;
        cycle();
        repeat (3) begin
            tick = 1'b1;
            cycle();
        end
        chk("pre_reset_G", g_o[0], 24);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("async_reset_R", r_o[0], 0);
        chk("async_reset_G", g_o[0], 0);
        chk("async_reset_busy", busy_o[0], 0);
        cycle();
        #2 rst = 1'b1;
        cycle();
        repeat (3) begin
            tick = 1'b1;
            cycle();
        end
        chk("post_reset_tick_G", g_o[0], 0);
        chk("post_reset_busy", busy_o[0], 0);
        repeat (2) cycle();

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
